// File: rtl/crossbar4_alloc_pkg.sv
// ============================================================================
// Module  : crossbar4_alloc_pkg
// Purpose : Shared constants, state encodings and small helpers for the
//           4x4 crossbar allocator and its round-robin arbiters.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package crossbar4_alloc_pkg;

  // Number of crossbar inputs and outputs; tied to the 2-bit selects.
  localparam int NUM_PORTS = 4;
  // Width of a port index / crossbar select.
  localparam int SEL_W     = 2;

  // Per-output allocation FSM encodings.
  localparam logic [0:0] ALLOC_IDLE = 1'b0;
  localparam logic [0:0] ALLOC_BUSY = 1'b1;

  typedef logic [SEL_W-1:0] port_idx_t;

  // Next index in round-robin order (wraps 3 -> 0).
  function automatic port_idx_t next_idx(input port_idx_t idx);
    return idx + port_idx_t'(1);
  endfunction

  // One-hot decode of a port index.
  function automatic logic [NUM_PORTS-1:0] idx_onehot(input port_idx_t idx);
    logic [NUM_PORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage : crossbar4_alloc_pkg

`default_nettype wire

// File: rtl/crossbar4_rr_arb.sv
// ============================================================================
// Module  : crossbar4_rr_arb
// Purpose : Combinational 4-way round-robin search. Returns the first set
//           request found starting at ptr and walking ptr+1, ptr+2, ...
//           modulo 4.
// Ports   : req   [3:0] in  - request vector, bit i = input i requests
//           ptr   [1:0] in  - highest-priority index for this search
//           any         out - at least one request is set
//           grant [1:0] out - index of the winning request (== ptr if none)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module crossbar4_rr_arb
  import crossbar4_alloc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic                 any,
  output logic [SEL_W-1:0]     grant
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so that the nearest set request
  // (lowest offset from ptr) is the last one to write grant.
  always_comb begin
    any   = |req;
    grant = ptr;
    idx   = ptr;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = ptr + k[SEL_W-1:0];
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

endmodule : crossbar4_rr_arb

`default_nettype wire

// File: rtl/crossbar4_alloc.sv
// ============================================================================
// Module  : crossbar4_alloc
// Purpose : Packet-level allocator / sequencer for a 4x4 crossbar. Each
//           output runs an IDLE/BUSY FSM with a round-robin arbiter; the
//           grant is held until the owner's last flit transfers, so
//           multi-flit packets are never interleaved at an output.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           in_val   [3:0] in   - input i presents a flit
//           in_dest0..3 [1:0]   - destination output of input i's flit
//           in_last  [3:0] in   - input i's flit is last of its packet
//           in_rdy   [3:0] out  - input i's flit is accepted this cycle
//           out_val  [3:0] out  - output o carries a valid flit
//           out_rdy  [3:0] in   - output o's sink accepts
//           sel0..3  [1:0] out  - crossbar select (source input) per output
//           out_busy [3:0] out  - output o is locked to an owner
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module crossbar4_alloc
  import crossbar4_alloc_pkg::*;
#(
  // Must be 4: selects and destination fields are fixed at 2 bits.
  parameter int p_num_ports = NUM_PORTS
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_num_ports-1:0] in_val,
  input  logic [SEL_W-1:0]       in_dest0,
  input  logic [SEL_W-1:0]       in_dest1,
  input  logic [SEL_W-1:0]       in_dest2,
  input  logic [SEL_W-1:0]       in_dest3,
  input  logic [p_num_ports-1:0] in_last,
  output logic [p_num_ports-1:0] in_rdy,
  output logic [p_num_ports-1:0] out_val,
  input  logic [p_num_ports-1:0] out_rdy,
  output logic [SEL_W-1:0]       sel0,
  output logic [SEL_W-1:0]       sel1,
  output logic [SEL_W-1:0]       sel2,
  output logic [SEL_W-1:0]       sel3,
  output logic [p_num_ports-1:0] out_busy
);

  logic [NUM_PORTS-1:0][SEL_W-1:0]     dest;
  logic [NUM_PORTS-1:0][SEL_W-1:0]     sel_w;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] rdy_term;

  assign dest = {in_dest3, in_dest2, in_dest1, in_dest0};

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [0:0]           state_q, state_d;
    logic [SEL_W-1:0]     own_q, own_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] req;
    logic                 arb_any;
    logic [SEL_W-1:0]     arb_grant;
    logic                 busy;
    logic                 xfer;
    logic                 last_xfer;

    always_comb begin
      req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[i] = in_val[i] && (dest[i] == SEL_W'(o));
      end
    end

    crossbar4_rr_arb u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .any   (arb_any),
      .grant (arb_grant)
    );

    // Handshake terms depend only on the registered owner, never on the
    // arbiter output, so no path exists from the search to out_val/in_rdy.
    // The owner must still be pointing at this output; a mid-packet
    // destination change drops out_val but keeps the lock.
    assign busy      = (state_q == ALLOC_BUSY);
    assign out_val[o] = busy && in_val[own_q] && (dest[own_q] == SEL_W'(o));
    assign xfer      = out_val[o] && out_rdy[o];
    assign last_xfer = xfer && in_last[own_q];
    assign rdy_term[o] = xfer ? idx_onehot(own_q) : '0;

    // The select follows the owner register: it equals the owner while BUSY
    // and keeps the previous owner while IDLE.
    assign sel_w[o]    = own_q;
    assign out_busy[o] = busy;

    always_comb begin
      state_d = state_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      case (state_q)
        ALLOC_IDLE: begin
          // Allocation cycle: latch the winner, no flit moves yet.
          if (arb_any) begin
            own_d   = arb_grant;
            state_d = ALLOC_BUSY;
          end
        end
        ALLOC_BUSY: begin
          // Release only on the owner's last flit; the pointer advances
          // past the releasing owner for fairness.
          if (last_xfer) begin
            state_d = ALLOC_IDLE;
            ptr_d   = next_idx(own_q);
          end
        end
        default: state_d = ALLOC_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ALLOC_IDLE;
        own_q   <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        own_q   <= own_d;
        ptr_q   <= ptr_d;
      end
    end
  end : g_out

  // An input has one destination, so at most one term per bit is set.
  always_comb begin
    in_rdy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_rdy = in_rdy | rdy_term[o];
    end
  end

  assign sel0 = sel_w[0];
  assign sel1 = sel_w[1];
  assign sel2 = sel_w[2];
  assign sel3 = sel_w[3];

endmodule : crossbar4_alloc

`default_nettype wire

// File: tb/tb_crossbar4_alloc.sv
// ============================================================================
// Module  : tb_crossbar4_alloc
// Purpose : Self-checking bench for crossbar4_alloc. Source models present
//           queued flits per input; expected transfers (output, cycle,
//           source) are pushed to per-output queues and a monitor pops and
//           compares on every out_val && out_rdy.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crossbar4_alloc;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_val, in_last, out_rdy;
  logic [3:0] in_rdy, out_val, out_busy;
  logic [1:0] dest_a [4];
  logic [1:0] sel0, sel1, sel2, sel3;
  logic [1:0] sel_a  [4];

  typedef struct {logic [1:0] dest; logic last;} flit_t;
  typedef struct {int cyc; logic [1:0] src;}     exp_t;

  flit_t      src_q [4][$];
  exp_t       exp_q [4][$];
  exp_t       mon_e;
  logic [3:0] fire = 4'b0;
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign sel_a[0] = sel0;
  assign sel_a[1] = sel1;
  assign sel_a[2] = sel2;
  assign sel_a[3] = sel3;

  crossbar4_alloc #(.p_num_ports(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_dest0 (dest_a[0]),
    .in_dest1 (dest_a[1]),
    .in_dest2 (dest_a[2]),
    .in_dest3 (dest_a[3]),
    .in_last  (in_last),
    .in_rdy   (in_rdy),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .sel0     (sel0),
    .sel1     (sel1),
    .sel2     (sel2),
    .sel3     (sel3),
    .out_busy (out_busy)
  );

  // Monitor: samples on the falling edge, records input handshakes for the
  // source models and checks every output transfer against the scoreboard.
  always @(negedge clk) begin
    fire = in_val & in_rdy;
    for (int o = 0; o < 4; o++) begin
      if (out_val[o] && out_rdy[o]) begin
        n_vec++;
        if (exp_q[o].size() == 0) begin
          n_err++;
          $display("FAIL xfer_out%0d cyc %0d: got transfer from src %0d, required none",
                   o, cyc, sel_a[o]);
        end else begin
          mon_e = exp_q[o].pop_front();
          if (mon_e.cyc != cyc || mon_e.src != sel_a[o] || !in_rdy[mon_e.src]) begin
            n_err++;
            $display("FAIL xfer_out%0d: got cyc %0d src %0d in_rdy %b, required cyc %0d src %0d rdy set",
                     o, cyc, sel_a[o], in_rdy, mon_e.cyc, mon_e.src);
          end
        end
      end
    end
    if ((|in_rdy) || (|(out_val & out_rdy))) begin
      n_vec++;
      if ($countones(in_rdy) != $countones(out_val & out_rdy)) begin
        n_err++;
        $display("FAIL rdy_count cyc %0d: got in_rdy %b, required one bit per transfer %b",
                 cyc, in_rdy, out_val & out_rdy);
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        in_val[i]  = 1'b1;
        in_last[i] = src_q[i][0].last;
        dest_a[i]  = src_q[i][0].dest;
      end else begin
        in_val[i]  = 1'b0;
        in_last[i] = 1'b0;
        dest_a[i]  = 2'd0;
      end
    end
  endtask

  // Advance one cycle: retire flits accepted in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic push(input int i, input logic [1:0] d, input int n);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.dest = d;
      f.last = (k == n - 1);
      src_q[i].push_back(f);
    end
  endtask

  task automatic expect_x(input int o, input int c, input logic [1:0] s);
    exp_t e;
    e.cyc = c;
    e.src = s;
    exp_q[o].push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int o = 0; o < 4; o++) n += exp_q[o].size();
    return n;
  endfunction

  task automatic drain(input int budget);
    int k = 0;
    while (pending() > 0 && k < budget) begin
      tick();
      k++;
    end
    n_vec++;
    if (pending() > 0) begin
      n_err++;
      $display("FAIL drain_timeout cyc %0d: got %0d transfers outstanding, required 0",
               cyc, pending());
      for (int o = 0; o < 4; o++) exp_q[o].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset   = 1'b1;
    out_rdy = 4'hF;
    drive();
    repeat (3) tick();
    reset = 1'b0;

    // Reset state held with idle inputs.
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      chk("idle_outputs", {8'd0, out_val, in_rdy, out_busy, sel3, sel2, sel1, sel0}, 32'd0);
    end

    // Input 2: 3-flit packet to output 1.
    b = cyc;
    push(2, 2'd1, 3);
    drive();
    for (int k = 1; k <= 3; k++) expect_x(1, b + k, 2'd2);
    repeat (3) tick();
    #1;
    chk("busy_during_pkt", {31'd0, out_busy[1]}, 32'd1);
    chk("sel1_during_pkt", {30'd0, sel1}, 32'd2);
    tick();
    #1;
    chk("busy_after_last", {28'd0, out_busy}, 32'd0);
    chk("sel1_holds_idle", {30'd0, sel1}, 32'd2);
    drain(10);

    // Pointer of output 1 now 3: input 3 beats input 0.
    b = cyc;
    push(0, 2'd1, 1);
    push(3, 2'd1, 1);
    drive();
    expect_x(1, b + 1, 2'd3);
    expect_x(1, b + 3, 2'd0);
    drain(12);

    // Inputs 0, 1, 3 each send two single-flit packets to output 0.
    b = cyc;
    for (int r = 0; r < 2; r++) begin
      push(0, 2'd0, 1);
      push(1, 2'd0, 1);
      push(3, 2'd0, 1);
    end
    drive();
    expect_x(0, b + 1, 2'd0);
    expect_x(0, b + 3, 2'd1);
    expect_x(0, b + 5, 2'd3);
    expect_x(0, b + 7, 2'd0);
    expect_x(0, b + 9, 2'd1);
    expect_x(0, b + 11, 2'd3);
    drain(30);

    // Input 0: 4 flits to output 2; input 1 joins mid-packet.
    b = cyc;
    push(0, 2'd2, 4);
    drive();
    for (int k = 1; k <= 4; k++) expect_x(2, b + k, 2'd0);
    repeat (2) tick();
    push(1, 2'd2, 2);
    drive();
    #1;
    chk("no_interleave_rdy", {28'd0, in_rdy}, 32'h1);
    expect_x(2, b + 6, 2'd1);
    expect_x(2, b + 7, 2'd1);
    drain(20);

    // Parallel: input i -> output 3-i, 4 flits each; stall output 2.
    b = cyc;
    push(0, 2'd3, 4);
    push(1, 2'd2, 4);
    push(2, 2'd1, 4);
    push(3, 2'd0, 4);
    drive();
    for (int k = 1; k <= 4; k++) begin
      expect_x(3, b + k, 2'd0);
      expect_x(1, b + k, 2'd2);
      expect_x(0, b + k, 2'd3);
    end
    expect_x(2, b + 1, 2'd1);
    expect_x(2, b + 4, 2'd1);
    expect_x(2, b + 5, 2'd1);
    expect_x(2, b + 6, 2'd1);
    tick();
    #1;
    chk("parallel_busy", {28'd0, out_busy}, 32'hF);
    chk("parallel_rdy", {28'd0, in_rdy}, 32'hF);
    tick();
    out_rdy = 4'b1011;
    #1;
    chk("stall_rdy", {28'd0, in_rdy}, 32'hD);
    tick();
    tick();
    out_rdy = 4'hF;
    drain(20);

    // Reset during the second flit of a 4-flit packet, then restart.
    b = cyc;
    push(0, 2'd0, 4);
    drive();
    expect_x(0, b + 1, 2'd0);
    tick();
    tick();
    reset   = 1'b1;
    out_rdy = 4'h0;
    tick();
    reset   = 1'b0;
    out_rdy = 4'hF;
    src_q[0].delete();
    push(0, 2'd0, 4);
    drive();
    #1;
    chk("after_reset", {20'd0, out_val, in_rdy, out_busy}, 32'd0);
    for (int k = 1; k <= 4; k++) expect_x(0, b + 3 + k, 2'd0);
    drain(15);
    tick();
    #1;
    chk("final_idle", {28'd0, out_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_crossbar4_alloc

`default_nettype wire
